// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the logic_pipe block: opcode encoding and default width.
package logic_pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

endpackage

// File: rtl/logic_pipe_core.sv
// Combinational operation decode: bitwise logic ops and rotate by B[SHW-1:0].
module logic_pipe_core
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_FUN,
    output logic [WIDTH-1:0] result
);

    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] ror_w;

    // Shifting a doubled copy of A gives a rotate; amount 0 returns A itself.
    assign amt   = B[SHW-1:0];
    assign rol_w = {A, A} << amt;
    assign ror_w = {A, A} >> amt;

    always_comb begin
        result = '0;
        case (ALU_FUN)
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_NAND: result = ~(A & B);
            OP_NOR:  result = ~(A | B);
            OP_XOR:  result = A ^ B;
            OP_XNOR: result = ~(A ^ B);
            OP_ROL:  result = rol_w[2*WIDTH-1:WIDTH];
            OP_ROR:  result = ror_w[WIDTH-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_pipe.sv
// Two-stage logic/rotate pipeline with valid/ready flow control on both sides.
// Handshake: a beat moves when its valid (Logic_Enable / Logic_Flag) and ready (In_Ready / Out_Ready) are both 1 at a rising edge.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_FUN,
    input  logic             Logic_Enable,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Logic_OUT,
    output logic             Logic_Flag,
    input  logic             Out_Ready,
    output logic             Zero_Flag,
    output logic             Parity_Flag
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_fun;
    logic [WIDTH-1:0] core_result;
    logic             s2_adv;

    // In_Ready depends only on state and Out_Ready, never on Logic_Enable.
    assign s2_adv   = !Logic_Flag | Out_Ready;
    assign In_Ready = !s1_valid | s2_adv;

    logic_pipe_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .A       (s1_a),
        .B       (s1_b),
        .ALU_FUN (s1_fun),
        .result  (core_result)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_fun      <= '0;
            Logic_Flag  <= 1'b0;
            Logic_OUT   <= '0;
            Zero_Flag   <= 1'b0;
            Parity_Flag <= 1'b0;
        end else begin
            // Output stage only reloads when S1 holds data, so an idle output keeps its last value.
            if (s2_adv) begin
                Logic_Flag <= s1_valid;
                if (s1_valid) begin
                    Logic_OUT   <= core_result;
                    Zero_Flag   <= (core_result == '0);
                    Parity_Flag <= ^core_result;
                end
            end
            if (In_Ready) begin
                s1_valid <= Logic_Enable;
                if (Logic_Enable) begin
                    s1_a   <= A;
                    s1_b   <= B;
                    s1_fun <= ALU_FUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: directed WIDTH=8 scenarios and a WIDTH=32 random regression, run concurrently.
module tb_logic_pipe;

  logic clk;

  // WIDTH=8 instance signals
  logic       rst8, en8, or8, ir8, flag8, zero8, par8;
  logic [7:0] a8, b8, out8;
  logic [2:0] fun8;

  // WIDTH=32 instance signals
  logic        rst32, en32, or32, ir32, flag32, zero32, par32;
  logic [31:0] a32, b32, out32;
  logic [2:0]  fun32;

  logic [9:0]  exp8_q[$];
  logic [33:0] exp32_q[$];

  int tests = 0;
  int fails = 0;
  bit done32 = 0;
  bit stalled8 = 0;
  bit stalled32 = 0;

  logic_pipe #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst8), .A(a8), .B(b8), .ALU_FUN(fun8), .Logic_Enable(en8),
    .In_Ready(ir8), .Logic_OUT(out8), .Logic_Flag(flag8), .Out_Ready(or8),
    .Zero_Flag(zero8), .Parity_Flag(par8)
  );

  logic_pipe #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst32), .A(a32), .B(b32), .ALU_FUN(fun32), .Logic_Enable(en32),
    .In_Ready(ir32), .Logic_OUT(out32), .Logic_Flag(flag32), .Out_Ready(or32),
    .Zero_Flag(zero32), .Parity_Flag(par32)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  // reference model: result of op on w-bit operands, computed bit by bit for rotates
  function automatic logic [63:0] ref_op(int w, logic [63:0] a, logic [63:0] b, logic [2:0] op);
    logic [63:0] mask, am, bm, r;
    int amt;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    amt = int'(bm[5:0]) % w;
    r = '0;
    case (op)
      3'd0: r = am & bm;
      3'd1: r = am | bm;
      3'd2: r = ~(am & bm);
      3'd3: r = ~(am | bm);
      3'd4: r = am ^ bm;
      3'd5: r = ~(am ^ bm);
      3'd6: for (int i = 0; i < w; i++) r[(i + amt) % w] = am[i];
      default: for (int i = 0; i < w; i++) r[i] = am[(i + amt) % w];
    endcase
    return r & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // scoreboard monitors: output must equal queue front whenever valid, pop on transfer
  always @(negedge clk) begin
    if (rst8) begin
      if (stalled8) check("w8_stall_flag_held", {63'd0, flag8}, 64'd1);
      if (flag8) begin
        if (exp8_q.size() == 0) begin
          check("w8_unexpected_output", {54'd0, par8, zero8, out8}, 64'd0 - 64'd1);
        end else begin
          check("w8_result", {54'd0, par8, zero8, out8}, {54'd0, exp8_q[0]});
          if (or8) void'(exp8_q.pop_front());
        end
      end
      stalled8 = flag8 && !or8;
    end else begin
      stalled8 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst32) begin
      if (stalled32) check("w32_stall_flag_held", {63'd0, flag32}, 64'd1);
      if (flag32) begin
        if (exp32_q.size() == 0) begin
          check("w32_unexpected_output", {30'd0, par32, zero32, out32}, 64'd0 - 64'd1);
        end else begin
          check("w32_result", {30'd0, par32, zero32, out32}, {30'd0, exp32_q[0]});
          if (or32) void'(exp32_q.pop_front());
        end
      end
      stalled32 = flag32 && !or32;
    end else begin
      stalled32 = 0;
    end
  end

  // drivers: called at posedge+1, return at posedge+1
  task automatic try8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output bit acc);
    logic [63:0] r;
    a8 = a; b8 = b; fun8 = op; en8 = 1'b1;
    @(negedge clk);
    acc = ir8;
    if (acc) begin
      r = ref_op(8, {56'd0, a}, {56'd0, b}, op);
      exp8_q.push_back({^r[7:0], (r[7:0] == 8'd0), r[7:0]});
    end
    @(posedge clk); #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit acc;
    int n;
    acc = 0;
    for (n = 0; n < 100 && !acc; n++) try8(a, b, op, acc);
    en8 = 1'b0;
    if (!acc) check("w8_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && exp8_q.size() > 0; i++) @(posedge clk);
    #1;
    check("w8_drained", 64'(exp8_q.size()), 64'd0);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit acc;
    logic [63:0] r;
    acc = 0;
    a32 = a; b32 = b; fun32 = op; en32 = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = ir32;
      @(posedge clk); #1;
    end
    en32 = 1'b0;
    if (acc) begin
      r = ref_op(32, {32'd0, a}, {32'd0, b}, op);
      exp32_q.push_back({^r[31:0], (r[31:0] == 32'd0), r[31:0]});
    end else begin
      check("w32_accept_timeout", 64'd0, 64'd1);
    end
  endtask

  // directed WIDTH=8 scenarios
  task automatic seq8();
    logic [7:0] ops_a[4];
    logic [7:0] ops_b[4];
    logic [2:0] ops_f[4];
    int idx;
    bit acc;
    rst8 = 1'b0; en8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; fun8 = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_flag", {63'd0, flag8}, 64'd0);
    check("reset_out", {56'd0, out8}, 64'd0);
    check("reset_zero_parity", {62'd0, zero8, par8}, 64'd0);
    check("reset_in_ready", {63'd0, ir8}, 64'd1);
    @(posedge clk); #1;
    rst8 = 1'b1;

    // XOR latency: result visible two cycles after the inputs are presented
    send8(8'hF0, 8'h3C, 3'b100);
    @(negedge clk);
    check("lat_not_early", {63'd0, flag8}, 64'd0);
    @(negedge clk);
    check("lat_flag", {63'd0, flag8}, 64'd1);
    check("lat_result", {54'd0, par8, zero8, out8}, {54'd0, 2'b00, 8'hCC});
    @(posedge clk); #1;
    drain8();

    send8(8'h81, 8'h01, 3'b110);
    send8(8'h01, 8'h09, 3'b111);
    send8(8'h0F, 8'hF0, 3'b000);
    send8(8'hA5, 8'h00, 3'b110);
    send8(8'h3C, 8'h08, 3'b111);
    drain8();

    // backpressure: only two accepts fit while the output is stalled
    ops_a = '{8'h12, 8'h34, 8'h56, 8'h78};
    ops_b = '{8'hFF, 8'h0F, 8'h03, 8'hAA};
    ops_f = '{3'b001, 3'b010, 3'b110, 3'b101};
    or8 = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      try8(ops_a[idx], ops_b[idx], ops_f[idx], acc);
      if (acc) idx++;
    end
    en8 = 1'b0;
    check("stall_accept_count", 64'(idx), 64'd2);
    @(negedge clk);
    check("stall_in_ready_low", {63'd0, ir8}, 64'd0);
    @(posedge clk); #1;
    or8 = 1'b1;
    while (idx < 4) begin
      send8(ops_a[idx], ops_b[idx], ops_f[idx]);
      idx++;
    end
    drain8();

    // streaming with Out_Ready toggled every cycle
    fork
      begin
        for (int i = 0; i < 10; i++)
          send8(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          or8 = ~or8;
        end
      end
    join
    or8 = 1'b1;
    drain8();

    // reset with two operations in flight
    send8(8'h11, 8'h22, 3'b001);
    send8(8'h33, 8'h44, 3'b100);
    rst8 = 1'b0;
    @(posedge clk);
    exp8_q.delete();
    @(negedge clk);
    check("midrst_flag", {63'd0, flag8}, 64'd0);
    check("midrst_out", {56'd0, out8}, 64'd0);
    check("midrst_in_ready", {63'd0, ir8}, 64'd1);
    @(posedge clk); #1;
    rst8 = 1'b1;
    send8(8'h00, 8'h00, 3'b011);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_nor", {54'd0, flag8, par8, out8}, {54'd0, 1'b1, 1'b0, 8'hFF});
    @(posedge clk); #1;
    drain8();
  endtask

  // WIDTH=32 random regression with random backpressure
  task automatic seq32();
    rst32 = 1'b0; en32 = 1'b0; a32 = '0; b32 = '0; fun32 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b1;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          send32($urandom, $urandom, 3'($urandom_range(0, 7)));
        end
        done32 = 1;
      end
      begin
        while (!done32) begin
          or32 = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        or32 = 1'b1;
      end
    join
    for (int i = 0; i < 100 && exp32_q.size() > 0; i++) @(posedge clk);
    #1;
    check("w32_drained", 64'(exp32_q.size()), 64'd0);
  endtask

  initial begin
    or32 = 1'b1;
    fork
      seq8();
      seq32();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal values are powers of two, 4..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), rotate-amount width derived from WIDTH; not overridden by users.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port A  input  WIDTH  operand A.
REQ-006 SHALL have port B  input  WIDTH  operand B; its low SHW bits are the rotate amount.
REQ-007 SHALL have port ALU_FUN  input  3  operation select.
REQ-008 SHALL have port Logic_Enable  input  1  input valid.
REQ-009 SHALL have port In_Ready  output  1  input ready; an operation is accepted when Logic_Enable=1 and In_Ready=1.
REQ-010 SHALL have port Logic_OUT  output  WIDTH  registered result.
REQ-011 SHALL have port Logic_Flag  output  1  output valid.
REQ-012 SHALL have port Out_Ready  input  1  downstream ready; a result transfers when Logic_Flag=1 and Out_Ready=1.
REQ-013 SHALL have port Zero_Flag  output  1  registered flag, Logic_OUT == 0.
REQ-014 SHALL have port Parity_Flag  output  1  registered flag, XOR-reduction of Logic_OUT.

Function
REQ-015 Operations SHALL be: 000 A&B, 001 A|B, 010 ~(A&B), 011 ~(A|B), 100 A^B, 101 ~(A^B), 110 A rotated left by B[SHW-1:0], 111 A rotated right by B[SHW-1:0].
REQ-016 A rotate amount of 0 SHALL return A unchanged; amounts wrap modulo WIDTH by construction.
REQ-017 Pipeline SHALL have two stages. S1 registers A, B and ALU_FUN on accept. S2 registers the computed result and both flags when S1 data advances.
REQ-018 With Out_Ready held 1, Logic_Flag SHALL assert exactly 2 cycles after the accepting edge, with the matching result; throughput is one operation per cycle.
REQ-019 S2 advance condition SHALL be s2_adv = !Logic_Flag | Out_Ready.
REQ-020 In_Ready SHALL equal !s1_valid | s2_adv, combinational from state and Out_Ready only, with no path from Logic_Enable.
REQ-021 While Logic_Flag=1 and Out_Ready=0, Logic_OUT, Zero_Flag, Parity_Flag and Logic_Flag SHALL hold stable.
REQ-022 When Logic_Flag=1, Out_Ready=1 and S1 is empty, Logic_Flag SHALL deassert on the next edge.
REQ-023 A simultaneous output transfer and input accept SHALL lose no data and duplicate no data; results leave in acceptance order.
REQ-024 With both stages full and Out_Ready=0, In_Ready SHALL be 0; Logic_Enable is ignored and A/B/ALU_FUN may change freely.
REQ-025 While Logic_Flag=0, Logic_OUT and the flags SHALL retain their last value (no X, no recompute).

Reset
REQ-026 On an edge with RST=0, SHALL clear s1_valid, Logic_Flag, Logic_OUT (all zeros), Zero_Flag and Parity_Flag to 0, and clear the S1 data registers to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; after release, the first accept yields a result 2 cycles later.
REQ-028 During reset, In_Ready SHALL read 1, since S1 is empty, but no accept takes effect on a reset edge.

Structure
REQ-029 A shared package SHALL hold the 3-bit opcode constants (OP_AND … OP_ROR) and the default WIDTH.
REQ-030 The operation decode plus rotate SHALL live in one combinational sub-module, logic_pipe_core (inputs A, B, ALU_FUN; output result). Pipeline control SHALL stay in logic_pipe.

Verification
REQ-031 WIDTH=8, Out_Ready=1: accept A=0xF0, B=0x3C, op 100 -> Logic_Flag=1 two cycles later, Logic_OUT=0xCC, Zero_Flag=0, Parity_Flag=0.
REQ-032 WIDTH=8: op 110, A=0x81, B=0x01 -> 0x03; op 111, A=0x01, B=0x09 (amount 1) -> 0x80; op 000, A=0x0F, B=0xF0 -> 0x00 with Zero_Flag=1.
REQ-033 Back-to-back 4 ops with Out_Ready=0 -> In_Ready falls after 2 accepts, Logic_OUT holds the first result. Then Out_Ready=1 -> all 4 results appear in order, none lost.
REQ-034 Streaming 10 ops with Out_Ready toggled each cycle -> the scoreboard matches all 10 results in order, and the output is stable during every stall.
REQ-035 RST=0 asserted while two operations are in flight -> next edge Logic_Flag=0, Logic_OUT=0. After release, a new op 011 with A=0x00, B=0x00 -> 0xFF, Parity_Flag=0.
REQ-036 WIDTH=32 regression: random ops and operands vs. reference model, 10k transactions with random backpressure, 0 mismatches.
